seg7_scanner: RTL and testbench
===============================

SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles one digit stays lit (ACTIVE phase); legal range >=2.
REQ-002 Parameter GAP_CYCLES, default 16: dead-time cycles with all digits off between digits; legal range >=1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 value  input  16  four hex digits; digit k = value[4k+3:4k], digit 0 rightmost.
REQ-006 value_valid  input  1  single-cycle strobe capturing value into shadow register.
REQ-007 digit_en  input  4  per-digit enable; bit k=0 keeps digit k dark.
REQ-008 lzb_en  input  1  leading-zero blanking enable.
REQ-009 number  output  4  nibble for the lit digit, fed to the hex-to-segment decoder.
REQ-010 selector  output  4  active-low digit select; bit k=0 lights digit k.
REQ-011 blank  output  1  high forces downstream segments off.
REQ-012 frame_start  output  1  one-cycle pulse on the first ACTIVE cycle of digit 0.

Function
REQ-013 Two-state FSM: ACTIVE (SCAN_DIV cycles) then GAP (GAP_CYCLES cycles), repeating; one ACTIVE+GAP pair per digit.
REQ-014 Phase counter counts 0..SCAN_DIV-1 in ACTIVE and 0..GAP_CYCLES-1 in GAP; reloads to 0 on each state change.
REQ-015 Digit index advances 0->1->2->3->0 on the GAP->ACTIVE transition; wraps 3->0; frame period = 4*(SCAN_DIV+GAP_CYCLES).
REQ-016 In GAP: selector=4'b1111, blank=1, number holds its last value.
REQ-017 In ACTIVE for index k: number = display digit k; selector bit k low, others high, unless digit k suppressed.
REQ-018 Digit k suppressed when digit_en[k]=0, or lzb_en=1, k>=1, and display digits k..3 all zero; digit 0 never blanked by LZB.
REQ-019 Suppressed digit: selector=4'b1111, blank=1 for the slot; slot timing unchanged.
REQ-020 value_valid=1 loads shadow register with value on that edge; later strobes overwrite earlier ones.
REQ-021 Display register loads from shadow on entry to ACTIVE for digit 0 only; digits of one frame never mix two values.
REQ-022 value_valid asserted on the same edge as digit-0 entry: new value bypasses to display register and is shown that frame.
REQ-023 digit_en and lzb_en sampled combinationally each cycle; changes take effect next cycle.
REQ-024 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-025 While rst=1: state=GAP, phase=0, index=3, shadow=display=16'h0000, selector=4'b1111, number=4'h0, blank=1, frame_start=0.
REQ-026 After rst deasserts, the first ACTIVE cycle is digit 0 after GAP_CYCLES cycles, with frame_start=1.
REQ-027 rst mid-frame immediately darkens all digits (selector=4'b1111) without waiting for a clock edge.

Structure
REQ-028 Shared package holds FSM state enum (ACTIVE, GAP), digit-count constant 4, and active-low selector-off constant 4'b1111.
REQ-029 One sub-module, seg7_prescaler: parameterised phase counter with terminal-count flag; FSM and digit logic stay in seg7_scanner.
REQ-030 Counter widths derived via clog2 of the respective parameter.

Verification (SCAN_DIV=4, GAP_CYCLES=2 unless noted)
REQ-031 Reset release, value=16'h1234 strobed -> frames show 4,3,2,1 on selector 1110,1101,1011,0111; each lit 4 cycles, 2-cycle gap with 1111.
REQ-032 lzb_en=1, value=16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0; value=16'h0000 -> only digit 0 lit, showing 0.
REQ-033 Strobe 16'hABCD while digit 2 is lit -> current frame completes with old value; next frame shows D,C,B,A.
REQ-034 Strobe 16'h9876 on the digit-0 entry edge -> that same frame shows 6,7,8,9 and frame_start=1 on that edge.
REQ-035 digit_en=4'b0101 -> digits 1 and 3 produce selector 1111 and blank=1; frame period stays 24 cycles.
REQ-036 rst asserted mid-ACTIVE -> selector 1111, blank=1 before the next edge; after release, behaviour per REQ-026.

Source files
------------

// File: rtl/seg7_scanner_pkg.sv
// Shared types and constants for the 4-digit multiplexed seven-segment scanner.
package seg7_scanner_pkg;

    typedef enum logic {
        StActive = 1'b0,
        StGap    = 1'b1
    } scan_state_e;

    localparam int unsigned NumDigits = 4;
    localparam logic [3:0]  SelOff    = 4'b1111;

    // A digit stays dark when disabled, or when leading-zero blanking is on and it and every
    // digit to its left are zero. Digit 0 is never blanked by LZB so zero still shows as "0".
    function automatic logic digit_suppressed(logic [15:0] disp, logic [1:0] idx,
                                              logic [3:0] en, logic lzb);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NumDigits; k++) begin
            if (k >= int'(idx) && disp[4*k +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        return !en[idx] || (lzb && idx != 2'd0 && upper_zero);
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Phase counter for the scanner: counts 0..len-1 for the current phase and flags the last cycle.
module seg7_prescaler #(
    parameter int unsigned ActiveLen = 4,
    parameter int unsigned GapLen    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic gap_i,
    output logic tc_o
);

    localparam int unsigned ActW = (ActiveLen > 1) ? $clog2(ActiveLen) : 1;
    localparam int unsigned GapW = (GapLen > 1) ? $clog2(GapLen) : 1;
    localparam int unsigned CntW = (ActW > GapW) ? ActW : GapW;

    logic [CntW-1:0] count_q, count_d;

    // Terminal count coincides with the FSM state change, so wrapping here is the reload.
    always_comb begin
        tc_o    = gap_i ? (count_q == CntW'(GapLen - 1)) : (count_q == CntW'(ActiveLen - 1));
        count_d = tc_o ? '0 : count_q + CntW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed 4-digit display scanner with dead-time gaps, digit enables and LZB.
module seg7_scanner
    import seg7_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_i,
    input  logic        value_valid_i,
    input  logic [3:0]  digit_en_i,
    input  logic        lzb_en_i,
    output logic [3:0]  number_o,
    output logic [3:0]  selector_o,
    output logic        blank_o,
    output logic        frame_start_o
);

    scan_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] disp_q, disp_d;
    logic [3:0]  number_q, number_d;
    logic [3:0]  selector_q, selector_d;
    logic        blank_q, blank_d;
    logic        frame_start_q, frame_start_d;
    logic        tc;

    seg7_prescaler #(
        .ActiveLen (SCAN_DIV),
        .GapLen    (GAP_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .gap_i (state_q == StGap),
        .tc_o  (tc)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        disp_d        = disp_q;
        shadow_d      = value_valid_i ? value_i : shadow_q;
        frame_start_d = 1'b0;
        if (tc) begin
            if (state_q == StGap) begin
                state_d = StActive;
                idx_d   = idx_q + 2'd1;
                if (idx_d == 2'd0) begin
                    // Same-edge strobe bypasses the shadow so it shows this frame.
                    disp_d        = value_valid_i ? value_i : shadow_q;
                    frame_start_d = 1'b1;
                end
            end else begin
                state_d = StGap;
            end
        end

        number_d   = number_q;
        selector_d = SelOff;
        blank_d    = 1'b1;
        if (state_d == StActive) begin
            number_d = disp_d[{idx_d, 2'b00} +: 4];
            if (!digit_suppressed(disp_d, idx_d, digit_en_i, lzb_en_i)) begin
                selector_d = ~(4'b0001 << idx_d);
                blank_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StGap;
            idx_q         <= 2'd3;
            shadow_q      <= 16'h0000;
            disp_q        <= 16'h0000;
            number_q      <= 4'h0;
            selector_q    <= SelOff;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            disp_q        <= disp_d;
            number_q      <= number_d;
            selector_q    <= selector_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign number_o      = number_q;
    assign selector_o    = selector_q;
    assign blank_o       = blank_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner with SCAN_DIV=4, GAP_CYCLES=2 (24-cycle frames).
module tb_seg7_scanner;

    localparam int FrameLen = 24;
    localparam int SlotLen  = 6;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        value_valid;
    logic [3:0]  digit_en;
    logic        lzb_en;
    logic [3:0]  number;
    logic [3:0]  selector;
    logic        blank;
    logic        frame_start;

    int n_tests;
    int n_fail;

    logic [3:0] cap_sel  [FrameLen];
    logic [3:0] cap_num  [FrameLen];
    logic       cap_blank[FrameLen];
    logic       cap_fs   [FrameLen];
    logic       cap_next_fs;

    seg7_scanner #(
        .SCAN_DIV   (4),
        .GAP_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .value_i       (value),
        .value_valid_i (value_valid),
        .digit_en_i    (digit_en),
        .lzb_en_i      (lzb_en),
        .number_o      (number),
        .selector_o    (selector),
        .blank_o       (blank),
        .frame_start_o (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected selector for frame cycle i given which digits should light.
    function automatic logic [3:0] exp_sel(logic [3:0] lit, int i);
        int slot;
        slot = i / SlotLen;
        if ((i % SlotLen) >= 4 || !lit[slot]) return 4'b1111;
        return ~(4'b0001 << slot);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        value       = v;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic wait_frame_start();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 40);
        n_tests++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_start_timeout: frame_start=%b after %0d cycles, want 1", frame_start, n);
        end
    endtask

    // Records one frame starting at the current cycle; optionally strobes a value at cycle strobe_at.
    task automatic capture_frame(input int strobe_at, input logic [15:0] sv);
        for (int i = 0; i < FrameLen; i++) begin
            cap_sel[i]   = selector;
            cap_num[i]   = number;
            cap_blank[i] = blank;
            cap_fs[i]    = frame_start;
            if (i == strobe_at) begin
                value       = sv;
                value_valid = 1'b1;
            end
            tick();
            value_valid = 1'b0;
        end
        cap_next_fs = frame_start;
    endtask

    task automatic test_reset();
        logic [3:0]  s;
        logic [15:0] v;
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (selector !== 4'b1111 || blank !== 1'b1 || number !== 4'h0 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: sel=%b blank=%b num=%h fs=%b, want 1111 1 0 0",
                     selector, blank, number, frame_start);
        end
        rst = 1'b0;
        value = 16'h1234;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        n_tests++;
        if (frame_start !== 1'b0 || selector !== 4'b1111) begin
            n_fail++;
            $display("FAIL release_gap: fs=%b sel=%b, want 0 1111", frame_start, selector);
        end
        tick();
        n_tests++;
        if (frame_start !== 1'b1 || selector !== 4'b1110 || number !== 4'h4) begin
            n_fail++;
            $display("FAIL first_digit0: fs=%b sel=%b num=%h, want 1 1110 4",
                     frame_start, selector, number);
        end
        capture_frame(-1, 16'h0);
        v = 16'h1234;
        for (int i = 0; i < FrameLen; i++) begin
            s = exp_sel(4'b1111, i);
            n_tests++;
            if (cap_sel[i] !== s || cap_blank[i] !== (s == 4'b1111) || cap_fs[i] !== (i == 0)
                || (s != 4'b1111 && cap_num[i] !== v[4*(i/SlotLen) +: 4])) begin
                n_fail++;
                $display("FAIL frame_1234 cyc %0d: sel=%b blank=%b num=%h fs=%b, want sel=%b num=%h",
                         i, cap_sel[i], cap_blank[i], cap_num[i], cap_fs[i], s, v[4*(i/SlotLen) +: 4]);
            end
        end
        n_tests++;
        if (cap_next_fs !== 1'b1) begin
            n_fail++;
            $display("FAIL period_1234: fs at cycle 24=%b, want 1", cap_next_fs);
        end
    endtask

    task automatic test_lzb();
        logic [3:0]  s;
        logic [15:0] vals [2];
        logic [3:0]  lits [2];
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        lits[0] = 4'b0011;
        lits[1] = 4'b0001;
        lzb_en = 1'b1;
        for (int t = 0; t < 2; t++) begin
            strobe(vals[t]);
            wait_frame_start();
            capture_frame(-1, 16'h0);
            for (int i = 0; i < FrameLen; i++) begin
                s = exp_sel(lits[t], i);
                n_tests++;
                if (cap_sel[i] !== s || cap_blank[i] !== (s == 4'b1111)
                    || (s != 4'b1111 && cap_num[i] !== vals[t][4*(i/SlotLen) +: 4])) begin
                    n_fail++;
                    $display("FAIL lzb_%h cyc %0d: sel=%b blank=%b num=%h, want sel=%b num=%h",
                             vals[t], i, cap_sel[i], cap_blank[i], cap_num[i], s,
                             vals[t][4*(i/SlotLen) +: 4]);
                end
            end
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_mid_strobe();
        logic [3:0]  s;
        logic [15:0] v;
        strobe(16'h5A5A);
        wait_frame_start();
        capture_frame(14, 16'hABCD);
        v = 16'h5A5A;
        for (int i = 0; i < FrameLen; i++) begin
            s = exp_sel(4'b1111, i);
            n_tests++;
            if (cap_sel[i] !== s || (s != 4'b1111 && cap_num[i] !== v[4*(i/SlotLen) +: 4])) begin
                n_fail++;
                $display("FAIL mid_old cyc %0d: sel=%b num=%h, want sel=%b num=%h",
                         i, cap_sel[i], cap_num[i], s, v[4*(i/SlotLen) +: 4]);
            end
        end
        capture_frame(-1, 16'h0);
        v = 16'hABCD;
        for (int i = 0; i < FrameLen; i++) begin
            s = exp_sel(4'b1111, i);
            n_tests++;
            if (cap_sel[i] !== s || cap_fs[i] !== (i == 0)
                || (s != 4'b1111 && cap_num[i] !== v[4*(i/SlotLen) +: 4])) begin
                n_fail++;
                $display("FAIL mid_new cyc %0d: sel=%b num=%h fs=%b, want sel=%b num=%h",
                         i, cap_sel[i], cap_num[i], cap_fs[i], s, v[4*(i/SlotLen) +: 4]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [3:0]  s;
        logic [15:0] v;
        capture_frame(23, 16'h9876);
        n_tests++;
        if (cap_num[0] !== 4'hD || cap_next_fs !== 1'b1 || number !== 4'h6 || selector !== 4'b1110) begin
            n_fail++;
            $display("FAIL bypass_entry: prev_num0=%h fs=%b num=%h sel=%b, want D 1 6 1110",
                     cap_num[0], cap_next_fs, number, selector);
        end
        capture_frame(-1, 16'h0);
        v = 16'h9876;
        for (int i = 0; i < FrameLen; i++) begin
            s = exp_sel(4'b1111, i);
            n_tests++;
            if (cap_sel[i] !== s || cap_fs[i] !== (i == 0)
                || (s != 4'b1111 && cap_num[i] !== v[4*(i/SlotLen) +: 4])) begin
                n_fail++;
                $display("FAIL bypass cyc %0d: sel=%b num=%h fs=%b, want sel=%b num=%h",
                         i, cap_sel[i], cap_num[i], cap_fs[i], s, v[4*(i/SlotLen) +: 4]);
            end
        end
    endtask

    task automatic test_digit_en();
        logic [3:0]  s;
        logic [15:0] v;
        digit_en = 4'b0101;
        wait_frame_start();
        capture_frame(-1, 16'h0);
        v = 16'h9876;
        for (int i = 0; i < FrameLen; i++) begin
            s = exp_sel(4'b0101, i);
            n_tests++;
            if (cap_sel[i] !== s || cap_blank[i] !== (s == 4'b1111)
                || (s != 4'b1111 && cap_num[i] !== v[4*(i/SlotLen) +: 4])) begin
                n_fail++;
                $display("FAIL digit_en cyc %0d: sel=%b blank=%b num=%h, want sel=%b num=%h",
                         i, cap_sel[i], cap_blank[i], cap_num[i], s, v[4*(i/SlotLen) +: 4]);
            end
        end
        n_tests++;
        if (cap_next_fs !== 1'b1) begin
            n_fail++;
            $display("FAIL digit_en_period: fs at cycle 24=%b, want 1", cap_next_fs);
        end
        digit_en = 4'b1111;
    endtask

    task automatic test_reset_mid();
        wait_frame_start();
        tick();
        n_tests++;
        if (selector !== 4'b1110 || blank !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_lit: sel=%b blank=%b, want 1110 0", selector, blank);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (selector !== 4'b1111 || blank !== 1'b1 || frame_start !== 1'b0 || number !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: sel=%b blank=%b fs=%b num=%h, want 1111 1 0 0",
                     selector, blank, frame_start, number);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (frame_start !== 1'b0 || selector !== 4'b1111) begin
            n_fail++;
            $display("FAIL rerelease_gap: fs=%b sel=%b, want 0 1111", frame_start, selector);
        end
        tick();
        n_tests++;
        if (frame_start !== 1'b1 || selector !== 4'b1110 || number !== 4'h0 || blank !== 1'b0) begin
            n_fail++;
            $display("FAIL rerelease_digit0: fs=%b sel=%b num=%h blank=%b, want 1 1110 0 0",
                     frame_start, selector, number, blank);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        value       = 16'h0000;
        value_valid = 1'b0;
        digit_en    = 4'b1111;
        lzb_en      = 1'b0;
        test_reset();
        test_lzb();
        test_mid_strobe();
        test_bypass();
        test_digit_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
